// File: rtl/mirfak_hazard_ctrl.sv
// Hazard controller for a three-stage ID/EX/WB pipeline: operand forwarding, load-use stall,
// multicycle mul/div wait and trap flush sequencing, plus a free-running stall-cycle counter.
module mirfak_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_we_i,
  input  logic        id_is_load_i,
  input  logic        id_take_branch_i,
  input  logic        ex_mdu_start_i,
  input  logic        ex_mdu_done_i,
  input  logic        wb_exception_i,
  input  logic        if_ready_i,
  output logic [1:0]  id_fwd_a_sel_o,
  output logic [1:0]  id_fwd_b_sel_o,
  output logic        if_enable_o,
  output logic        ifid_clear_o,
  output logic        idex_enable_o,
  output logic        idex_clear_o,
  output logic        exwb_enable_o,
  output logic        exwb_clear_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {StRun, StMduWait, StTrapFlush, StTrapWait} state_e;

  state_e      state_q;
  logic        ex_valid_q, ex_we_q, ex_load_q;
  logic [4:0]  ex_rd_q;
  logic        wb_valid_q, wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] stall_cnt_q;

  logic ex_fwd_ok, wb_fwd_ok;
  logic load_use;

  // Loads cannot forward from EX; their data only exists once they reach WB.
  assign ex_fwd_ok = ex_valid_q & ex_we_q & ~ex_load_q & (ex_rd_q != 5'd0);
  assign wb_fwd_ok = wb_valid_q & wb_we_q & (wb_rd_q != 5'd0);

  always_comb begin
    id_fwd_a_sel_o = 2'b00;
    id_fwd_b_sel_o = 2'b00;
    if (ex_fwd_ok && (ex_rd_q == id_rs1_i)) begin
      id_fwd_a_sel_o = 2'b01;
    end else if (wb_fwd_ok && (wb_rd_q == id_rs1_i)) begin
      id_fwd_a_sel_o = 2'b10;
    end
    if (ex_fwd_ok && (ex_rd_q == id_rs2_i)) begin
      id_fwd_b_sel_o = 2'b01;
    end else if (wb_fwd_ok && (wb_rd_q == id_rs2_i)) begin
      id_fwd_b_sel_o = 2'b10;
    end
  end

  assign load_use = id_valid_i & ex_valid_q & ex_load_q & (ex_rd_q != 5'd0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_rd_q)) |
                     (id_use_rs2_i & (id_rs2_i == ex_rd_q)));

  always_comb begin
    if_enable_o   = 1'b0;
    ifid_clear_o  = 1'b0;
    idex_enable_o = 1'b0;
    idex_clear_o  = 1'b0;
    exwb_enable_o = 1'b0;
    exwb_clear_o  = 1'b0;
    if (rst_i) begin
      ifid_clear_o = 1'b1;
      idex_clear_o = 1'b1;
      exwb_clear_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            // Hold IF/ID, let the load drain into WB, inject a bubble into EX.
            idex_clear_o  = 1'b1;
            exwb_enable_o = 1'b1;
          end else begin
            if_enable_o   = 1'b1;
            idex_enable_o = 1'b1;
            exwb_enable_o = 1'b1;
            ifid_clear_o  = id_take_branch_i;
          end
        end
        StMduWait: begin
        end
        StTrapFlush: begin
          ifid_clear_o = 1'b1;
          idex_clear_o = 1'b1;
          exwb_clear_o = 1'b1;
        end
        StTrapWait: begin
          if_enable_o  = 1'b1;
          idex_clear_o = 1'b1;
          exwb_clear_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else if (wb_exception_i) begin
      state_q <= StTrapFlush;
    end else begin
      unique case (state_q)
        StRun:       if (ex_mdu_start_i && !ex_mdu_done_i) state_q <= StMduWait;
        StMduWait:   if (ex_mdu_done_i) state_q <= StRun;
        StTrapFlush: state_q <= StTrapWait;
        StTrapWait:  if (if_ready_i) state_q <= StRun;
        default:     state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_we_q    <= 1'b0;
      ex_load_q  <= 1'b0;
    end else if (idex_clear_o) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_we_q    <= 1'b0;
      ex_load_q  <= 1'b0;
    end else if (idex_enable_o) begin
      ex_valid_q <= id_valid_i;
      ex_rd_q    <= id_rd_i;
      ex_we_q    <= id_we_i;
      ex_load_q  <= id_is_load_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_we_q    <= 1'b0;
    end else if (exwb_clear_o) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_we_q    <= 1'b0;
    end else if (exwb_enable_o) begin
      wb_valid_q <= ex_valid_q;
      wb_rd_q    <= ex_rd_q;
      wb_we_q    <= ex_we_q;
    end
  end

  // Counts every cycle in which EX does not accept a new instruction; wraps freely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
    end else if (!idex_enable_o || (state_q != StRun)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/mirfak_hazard_ctrl.md
MIRFAK_HAZARD_CTRL -- requirements
Module: mirfak_hazard_ctrl

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst_i  in  1  asynchronous, active-high reset.
REQ-003 id_valid_i  in  1  ID holds a real instruction, not a bubble.
REQ-004 id_rs1_i, id_rs2_i  in  5 each  ID source register addresses (instruction bits 19:15, 24:20).
REQ-005 id_use_rs1_i, id_use_rs2_i  in  1 each  ID instruction reads rs1 / rs2.
REQ-006 id_rd_i  in  5; id_we_i  in  1; id_is_load_i  in  1  ID destination, write enable, load flag.
REQ-007 id_take_branch_i  in  1  ID resolved a taken branch or jump.
REQ-008 ex_mdu_start_i  in  1  EX started a multicycle mul/div op.
REQ-009 ex_mdu_done_i  in  1  mul/div result valid this cycle.
REQ-010 wb_exception_i  in  1  trap or xRET commits in WB.
REQ-011 if_ready_i  in  1  IF accepted the trap redirect.
REQ-012 id_fwd_a_sel_o, id_fwd_b_sel_o  out  2 each  00 = regfile, 01 = EX result, 10 = WB result.
REQ-013 if_enable_o, ifid_clear_o, idex_enable_o, idex_clear_o, exwb_enable_o, exwb_clear_o  out  1 each  stage register controls.
REQ-014 stall_cnt_o  out  32  count of stall cycles.

Function
REQ-015 Shadow EX register holds {valid, rd, we, is_load}; it SHALL load the ID fields when idex_enable_o=1 and SHALL be zeroed when idex_clear_o=1; clear has priority.
REQ-016 Shadow WB register holds {valid, rd, we}; it SHALL load shadow EX (minus is_load) when exwb_enable_o=1 and SHALL be zeroed when exwb_clear_o=1.
REQ-017 Each fwd_sel SHALL be 01 when the shadow EX entry is valid, writes, has rd equal to the source and nonzero rd, and is not a load.
REQ-018 Otherwise each fwd_sel SHALL be 10 when the same conditions hold against shadow WB; otherwise 00.
REQ-019 When EX and WB both match, EX SHALL win; rd=x0 SHALL never forward.
REQ-020 Load-use: when shadow EX is a valid load with rd≠0 matching a used source of a valid ID instruction, the block SHALL assert if_enable_o=0, idex_enable_o=0, exwb_enable_o=1 and exwb_clear_o=0, and SHALL drive idex_clear_o=1 so that a bubble enters EX; the stall lasts exactly 1 cycle.
REQ-021 FSM states: RUN, MDU_WAIT, TRAP_FLUSH, TRAP_WAIT; reset state RUN.
REQ-022 RUN -> MDU_WAIT on ex_mdu_start_i when ex_mdu_done_i=0; MDU_WAIT drives all enables 0 and no clears; MDU_WAIT -> RUN on ex_mdu_done_i; ex_mdu_done_i on the cycle of ex_mdu_start_i SHALL keep the FSM in RUN.
REQ-023 wb_exception_i from any state SHALL enter TRAP_FLUSH, overriding the MDU wait and the load-use stall.
REQ-024 In TRAP_FLUSH, all three clears SHALL be 1 and both shadow registers SHALL be zeroed; it lasts 1 cycle, then TRAP_WAIT.
REQ-025 TRAP_WAIT SHALL hold if_enable_o=1, idex_clear_o=1 and exwb_clear_o=1, and SHALL go to RUN in the cycle after if_ready_i=1.
REQ-026 In RUN, with no stall, all enables SHALL be 1 and all clears 0, except that id_take_branch_i=1 with idex_enable_o=1 SHALL set ifid_clear_o=1.
REQ-027 A taken branch SHALL be ignored, with no ifid clear, while a load-use stall is active.
REQ-028 stall_cnt_o SHALL increment by 1 each cycle that idex_enable_o=0 or the FSM is not in RUN, wrap from FFFFFFFF to 0, and never saturate.
REQ-029 All outputs SHALL be registered or derived from state plus the current inputs; there SHALL be no combinational loop through the enable outputs.

Reset
REQ-030 While rst_i=1: FSM=RUN, shadows zeroed, stall_cnt_o=0, fwd selects 00, all enables 0, all clears 1.
REQ-031 In the first cycle after rst_i deasserts, the outputs SHALL follow RUN rules; reset asserted mid-MDU_WAIT or mid-TRAP_WAIT SHALL abort the operation immediately.

Verification
REQ-032 addi x5 in EX, ID add x6,x5,x5 -> fwd_a=fwd_b=01.
REQ-033 x5 written in both EX and WB, ID reads x5 -> 01; ID reads x0 while EX writes x0 -> 00.
REQ-034 lw x7 in EX, ID uses x7 -> one cycle with idex_enable=0 and idex_clear=1, stall_cnt +1; next cycle fwd=10.
REQ-035 ex_mdu_start, done after 5 cycles -> enables 0 for 5 cycles, stall_cnt=5, then RUN.
REQ-036 wb_exception during MDU_WAIT -> TRAP_FLUSH, all clears=1; if_ready after 3 cycles -> RUN one cycle later.
REQ-037 Taken branch in RUN -> ifid_clear=1; taken branch together with a load-use stall -> ifid_clear=0.
